divide_tokens: RTL and testbench

- Multi-channel serial token divider, successor to the single-channel halver.
- Each lane forwards every D-th incoming '1' token and drops the rest; D is runtime-programmable and shared by all lanes.
- Adds a gating enable, a saturating emitted-token counter and divisor-error reporting.
- Sits on serial event streams (strobes, credits) ahead of rate-reduced consumers.

---
 rtl/divide_tokens_pkg.sv | 12 +
 rtl/divide_tokens_lane.sv | 43 ++++
 rtl/divide_tokens.sv | 101 ++++++++++
 tb/tb_divide_tokens.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/divide_tokens_pkg.sv
// Shared defaults and types for the multi-lane token divider.
// Defaults describe the power-up configuration: four-bit divisor, eight-bit
// emitted-token counter, and a reset divisor of two (plain halving).
package divide_tokens_pkg;

    localparam int DIV_W_DEF     = 4;
    localparam int CNT_W_DEF     = 8;
    localparam int DIV_RESET_DEF = 2;

    typedef logic [DIV_W_DEF-1:0] div_t;

endpackage

// File: rtl/divide_tokens_lane.sv
// One token lane: forwards every D-th incoming token, drops the rest.
// Latency: b is registered, high the cycle after the D-th token is sampled.
// No backpressure: en=0 freezes the phase, clr zeroes phase and output.
module divide_tokens_lane #(
    parameter int DIV_W = divide_tokens_pkg::DIV_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [DIV_W-1:0] div,
    input  logic             a,
    output logic             b
);

    logic [DIV_W-1:0] phase;
    logic [DIV_W-1:0] phase_inc;

    // Phase never exceeds div-1, so the increment cannot wrap.
    assign phase_inc = phase + 1'b1;

    // Phase counter and output flop; clear beats tokens, idle cycles hold phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase <= '0;
            b     <= 1'b0;
        end else if (clr) begin
            phase <= '0;
            b     <= 1'b0;
        end else if (en && a) begin
            if (phase_inc == div) begin
                phase <= '0;
                b     <= 1'b1;
            end else begin
                phase <= phase_inc;
                b     <= 1'b0;
            end
        end else begin
            b <= 1'b0;
        end
    end

endmodule

// File: rtl/divide_tokens.sv
// Multi-lane token divider with shared programmable divisor and emit counter.
// Latency: one cycle from the D-th token to its b pulse; pass_total tracks b.
// No backpressure: a load cycle discards that cycle's tokens on every lane.
module divide_tokens #(
    parameter int CHANNELS  = 4,
    parameter int DIV_W     = divide_tokens_pkg::DIV_W_DEF,
    parameter int CNT_W     = divide_tokens_pkg::CNT_W_DEF,
    parameter int DIV_RESET = divide_tokens_pkg::DIV_RESET_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [DIV_W-1:0]    div,
    input  logic                div_load,
    input  logic [CHANNELS-1:0] a,
    output logic [CHANNELS-1:0] b,
    output logic [CNT_W-1:0]    pass_total,
    output logic                div_err
);

    import divide_tokens_pkg::*;

    localparam int              POP_W   = $clog2(CHANNELS + 1);
    localparam int              SUM_W   = CNT_W + POP_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [DIV_W-1:0] divisor;
    logic             load_ok;
    logic             lane_en;
    logic [CNT_W-1:0] base_total;
    logic [POP_W-1:0] pop;
    logic [SUM_W-1:0] sum;

    // A load with a non-zero value re-arms everything; any load cycle drops tokens.
    assign load_ok = div_load && (div != '0);
    assign lane_en = en && !div_load;

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_lane
            divide_tokens_lane #(
                .DIV_W (DIV_W)
            ) u_lane (
                .clk (clk),
                .rst (rst),
                .en  (lane_en),
                .clr (load_ok),
                .div (divisor),
                .a   (a[gi]),
                .b   (b[gi])
            );
        end
    endgenerate

    // Divisor register and sticky error; a zero load keeps the old divisor.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            divisor <= DIV_W'(DIV_RESET);
            div_err <= 1'b0;
        end else if (div_load) begin
            if (load_ok) begin
                divisor <= div;
                div_err <= 1'b0;
            end else begin
                div_err <= 1'b1;
            end
        end
    end

    // Population count of the registered lane outputs.
    always_comb begin
        pop = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            pop = pop + POP_W'(b[i]);
        end
    end

    // base_total holds pulses already retired from b; the live b pulses are
    // added on top so pass_total moves on the same edge as b.
    always_comb begin
        sum = SUM_W'(base_total) + SUM_W'(pop);
        if (sum > SUM_W'(CNT_MAX)) begin
            pass_total = CNT_MAX;
        end else begin
            pass_total = sum[CNT_W-1:0];
        end
    end

    // Fold the current pulses into the base each edge; a good load zeroes it
    // in the same edge that clears b, so the visible total reads zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_total <= '0;
        end else if (load_ok) begin
            base_total <= '0;
        end else begin
            base_total <= pass_total;
        end
    end

endmodule

// File: tb/tb_divide_tokens.sv
// Directed bench for divide_tokens, with a second instance using a 4-bit
// counter to exercise saturation. Inputs change 1ns after each rising edge,
// outputs are sampled at that same point.
module tb_divide_tokens;

    logic       clk;
    logic       rst;
    logic       en;
    logic [3:0] div;
    logic       div_load;
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] pass_total;
    logic       div_err;
    logic [3:0] b_s;
    logic [3:0] pass_total_s;
    logic       div_err_s;

    int n_pass;
    int n_total;

    divide_tokens dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .div        (div),
        .div_load   (div_load),
        .a          (a),
        .b          (b),
        .pass_total (pass_total),
        .div_err    (div_err)
    );

    divide_tokens #(.CNT_W(4)) dut_s (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .div        (div),
        .div_load   (div_load),
        .a          (a),
        .b          (b_s),
        .pass_total (pass_total_s),
        .div_err    (div_err_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [3:0] d);
        div      = d;
        div_load = 1'b1;
        a        = 4'b0000;
        tick();
        div_load = 1'b0;
    endtask

    logic [15:0] vec1;
    logic [15:0] exp1;
    logic [8:0]  exp2;

    initial begin
        n_pass   = 0;
        n_total  = 0;
        rst      = 1'b1;
        en       = 1'b0;
        div      = 4'd0;
        div_load = 1'b0;
        a        = 4'b0000;

        // Reset state before any clock edge.
        #1;
        check("rst_b",   32'(b),          32'h0);
        check("rst_pt",  32'(pass_total), 32'h0);
        check("rst_err", 32'(div_err),    32'h0);
        tick();
        rst = 1'b0;
        en  = 1'b1;

        // 1: halving on lane 0 with the reset divisor.
        vec1 = 16'b1100111010001111;
        exp1 = 16'b0100010010000101;
        for (int k = 0; k < 16; k++) begin
            a = {3'b000, vec1[15-k]};
            tick();
            check("t1_b", 32'(b), 32'({3'b000, exp1[15-k]}));
        end
        a = 4'b0000;
        check("t1_pt", 32'(pass_total), 32'd5);

        // 2: divide by three on lane 1.
        do_load(4'd3);
        check("t2_load_b",  32'(b),          32'h0);
        check("t2_load_pt", 32'(pass_total), 32'h0);
        exp2 = 9'b001001001;
        for (int k = 0; k < 9; k++) begin
            a = 4'b0010;
            tick();
            check("t2_b", 32'(b), 32'({2'b00, exp2[8-k], 1'b0}));
        end
        a = 4'b0000;
        check("t2_pt", 32'(pass_total), 32'd3);

        // 3: pass-through on all lanes, plus counter saturation.
        do_load(4'd1);
        for (int k = 0; k < 4; k++) begin
            a = 4'b1111;
            tick();
            check("t3_b", 32'(b), 32'hF);
        end
        check("t3_pt16",   32'(pass_total),   32'd16);
        check("t3_sat4",   32'(pass_total_s), 32'd15);
        tick();
        check("t3_pt20",   32'(pass_total),   32'd20);
        check("t3_sat5",   32'(pass_total_s), 32'd15);
        a = 4'b0000;
        tick();
        check("t3_b_idle", 32'(b), 32'h0);
        check("t3_sat_hold", 32'(pass_total_s), 32'd15);

        // 4: zero divisor load is rejected but still drops the token.
        do_load(4'd3);
        a = 4'b0001;
        tick();
        tick();
        check("t4_b_pre", 32'(b), 32'h0);
        div      = 4'd0;
        div_load = 1'b1;
        tick();
        div_load = 1'b0;
        check("t4_err",     32'(div_err),    32'h1);
        check("t4_b_drop",  32'(b),          32'h0);
        check("t4_pt_keep", 32'(pass_total), 32'h0);
        tick();
        check("t4_b_emit",  32'(b),          32'h1);
        check("t4_pt1",     32'(pass_total), 32'd1);
        check("t4_err_st",  32'(div_err),    32'h1);
        do_load(4'd2);
        check("t4_err_clr", 32'(div_err),    32'h0);
        check("t4_pt_clr",  32'(pass_total), 32'h0);

        // 5: en=0 freezes phases mid-count.
        do_load(4'd3);
        a = 4'b1111;
        tick();
        tick();
        en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("t5_b_gated", 32'(b), 32'h0);
        end
        en = 1'b1;
        tick();
        check("t5_b_resume", 32'(b),          32'hF);
        check("t5_pt",       32'(pass_total), 32'd4);
        a = 4'b0000;

        // 6: async reset mid-stream clears phase, pending pulse and count.
        do_load(4'd4);
        a = 4'b1000;
        tick();
        a = 4'b1100;
        tick();
        tick();
        tick();
        check("t6_b_pre",  32'(b),          32'h8);
        check("t6_pt_pre", 32'(pass_total), 32'd1);
        a = 4'b0000;
        #2;
        rst = 1'b1;
        #1;
        check("t6_rst_b",   32'(b),          32'h0);
        check("t6_rst_pt",  32'(pass_total), 32'h0);
        check("t6_rst_err", 32'(div_err),    32'h0);
        tick();
        rst = 1'b0;
        a = 4'b0100;
        tick();
        check("t6_tok1", 32'(b), 32'h0);
        tick();
        check("t6_tok2", 32'(b), 32'h4);
        check("t6_pt",   32'(pass_total), 32'd1);
        a = 4'b0000;
        tick();
        check("t6_idle", 32'(b), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
